// File: rtl/fact_seq_ctrl.sv
// Factorial sequencer: n! by shift-and-add multiply
// on a time-shared external adder.
module fact_seq_ctrl #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               op_start,
  input  logic [N_WIDTH-1:0] op_n,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_ci,
  input  logic [WIDTH-1:0]   add_s,
  input  logic               add_co,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int BW = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;
  localparam int XW = WIDTH + N_WIDTH;

  typedef enum logic [2:0] {
    IDLE, CHECK, MUL, UPD, DONE
  } state_e;

  state_e             state_q, state_d;
  logic [N_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [BW-1:0]      bitidx_q, bitidx_d;
  logic               ovf_q, ovf_d;

  logic [XW-1:0]      ext;
  logic               mbit;
  logic               lost;

  // Widened shift exposes the bits that truncation would drop.
  assign ext  = {{N_WIDTH{1'b0}}, result_q} << bitidx_q;
  assign mbit = cnt_q[bitidx_q];
  assign lost = |ext[XW-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    bitidx_d = bitidx_q;
    ovf_d    = ovf_q;
    add_a    = '0;
    add_b    = '0;
    unique case (state_q)
      IDLE: begin
        if (op_start) begin
          cnt_d    = op_n;
          result_d = WIDTH'(1);
          ovf_d    = 1'b0;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (cnt_q <= N_WIDTH'(1)) begin
          state_d = DONE;
        end else begin
          acc_d    = '0;
          bitidx_d = '0;
          state_d  = MUL;
        end
      end
      MUL: begin
        add_a = acc_q;
        if (mbit) add_b = ext[WIDTH-1:0];
        acc_d = add_s;
        if (add_co || (mbit && lost)) ovf_d = 1'b1;
        if (bitidx_q == BW'(N_WIDTH - 1)) begin
          state_d = UPD;
        end else begin
          bitidx_d = bitidx_q + BW'(1);
        end
      end
      UPD: begin
        result_d = acc_q;
        cnt_d    = cnt_q - N_WIDTH'(1);
        state_d  = CHECK;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      bitidx_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      bitidx_q <= bitidx_d;
      ovf_q    <= ovf_d;
    end
  end

  assign add_ci   = 1'b0;
  assign result   = result_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule
